// File: rtl/fmesh_destp_encoder_if.sv
// Flit handshake bundle for fmesh_destp_encoder: the incoming flit channel
// plus the outgoing routed-flit channel. The encoder uses the slave modport,
// and whatever feeds flits in and takes routed flits out uses the master modport.
interface fmesh_destp_encoder_if #(
  parameter int EAw = 9,
  parameter int PLw = 4
);
  logic           in_valid;
  logic           in_ready;
  logic           in_head;
  logic           in_tail;
  logic [EAw-1:0] in_dest_e_addr;
  logic           out_valid;
  logic           out_ready;
  logic           out_head;
  logic           out_tail;
  logic [3:0]     dest_port_coded;
  logic [PLw-1:0] endp_localp_num;

  modport slave (
    input  in_valid, in_head, in_tail, in_dest_e_addr, out_ready,
    output in_ready, out_valid, out_head, out_tail, dest_port_coded, endp_localp_num
  );

  modport master (
    output in_valid, in_head, in_tail, in_dest_e_addr, out_ready,
    input  in_ready, out_valid, out_head, out_tail, dest_port_coded, endp_localp_num
  );
endinterface

// File: rtl/fmesh_destp_encoder.sv
// fmesh_destp_encoder: per-input-port route computation for the fmesh router.
// The head flit's destination {ep,ey,ex} is compared with the router's own
// {y,x}. This produces the coded port {x,y,a,b} and the local port number.
// Both are held for the rest of the packet and pass through one registered
// valid/ready stage.
// Optional feature: define FMESH_DESTP_ADDR_CHECK_EN to drop packets whose
// head flit addresses a router or endpoint outside the mesh.
module fmesh_destp_encoder #(
  parameter int    T1         = 4,
  parameter int    T2         = 4,
  parameter int    T3         = 1,
  parameter int    EAw        = 9,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    PLw        = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [$clog2(T1)+$clog2(T2)-1:0]   current_r_addr,
  output logic [7:0]                         err_cnt,
  fmesh_destp_encoder_if.slave               bus
);

  localparam int NX  = T1;
  localparam int NY  = T2;
  localparam int NL  = T3;
  localparam int EXw = $clog2(NX);
  localparam int EYw = $clog2(NY);
  localparam int EPw = EAw - EXw - EYw;
  localparam bit IS_DET = (ROUTE_TYPE == "DETERMINISTIC");
`ifdef FMESH_DESTP_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DROP} state_t;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic           out_head_q, out_head_d;
  logic           out_tail_q, out_tail_d;
  logic [3:0]     coded_q, coded_d;
  logic [PLw-1:0] localp_q, localp_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic [EXw-1:0] cx, dx;
  logic [EYw-1:0] cy, dy;
  logic [EPw-1:0] ep;
  logic           go_east, go_north, x_diff, y_diff, y_keep;
  logic [3:0]     route_coded;
  logic [PLw-1:0] route_lp;
  logic           addr_bad;
  logic           accept;
  logic           err_inc;

  assign cx = current_r_addr[EXw-1:0];
  assign cy = current_r_addr[EXw +: EYw];
  assign dx = bus.in_dest_e_addr[EXw-1:0];
  assign dy = bus.in_dest_e_addr[EXw +: EYw];
  assign ep = bus.in_dest_e_addr[EXw+EYw +: EPw];

  assign addr_bad = ADDR_CHECK &&
                    ((int'(dx) > NX - 1) || (int'(dy) > NY - 1) || (int'(ep) > 4 + NL - 1));

  // A new flit can enter whenever the output slot is empty or being drained.
  assign accept = bus.in_valid & bus.in_ready;

  // Route decode of the incoming destination; XY routing suppresses y while x still differs.
  always_comb begin
    go_east  = (dx > cx);
    go_north = (dy < cy);
    x_diff   = (dx != cx);
    y_diff   = (dy != cy);
    y_keep   = y_diff;
    if (IS_DET && x_diff) begin
      y_keep = 1'b0;
    end
    route_coded = {go_east, go_north, x_diff, y_keep};
    route_lp    = PLw'(ep);
  end

  // Packet tracking and output stage: head flits latch a route, bodies reuse it, strays are dropped.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_head_d  = out_head_q;
    out_tail_d  = out_tail_q;
    coded_d     = coded_q;
    localp_d    = localp_q;
    err_inc     = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        ST_IDLE, ST_PKT: begin
          if (bus.in_head) begin
            // A head inside an open packet, or an out-of-range head, is counted once.
            if (addr_bad || (state_q == ST_PKT)) begin
              err_inc = 1'b1;
            end
            if (addr_bad) begin
              state_d = bus.in_tail ? ST_IDLE : ST_DROP;
            end else begin
              out_valid_d = 1'b1;
              out_head_d  = 1'b1;
              out_tail_d  = bus.in_tail;
              coded_d     = route_coded;
              localp_d    = route_lp;
              state_d     = bus.in_tail ? ST_IDLE : ST_PKT;
            end
          end else if (state_q == ST_PKT) begin
            out_valid_d = 1'b1;
            out_head_d  = 1'b0;
            out_tail_d  = bus.in_tail;
            state_d     = bus.in_tail ? ST_IDLE : ST_PKT;
          end else begin
            err_inc = 1'b1;
            state_d = bus.in_tail ? ST_IDLE : ST_DROP;
          end
        end
        ST_DROP: begin
          if (bus.in_tail) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
      coded_q     <= 4'b0000;
      localp_q    <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_head_q  <= out_head_d;
      out_tail_q  <= out_tail_d;
      coded_q     <= coded_d;
      localp_q    <= localp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready        = ~out_valid_q | bus.out_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_head        = out_head_q;
  assign bus.out_tail        = out_tail_q;
  assign bus.dest_port_coded = coded_q;
  assign bus.endp_localp_num = localp_q;
  assign err_cnt             = err_cnt_q;

endmodule

// File: tb/tb_fmesh_destp_encoder.sv
// Testbench for fmesh_destp_encoder: an XY-routed instance and an adaptive
// instance see the same flit stream. Both are compared against a packet-level
// reference model.
module tb_fmesh_destp_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] cur_addr;
  logic [7:0] err_det, err_ad;
  int         checks;
  int         errors;

  fmesh_destp_encoder_if #(.EAw(9), .PLw(4)) bus_d ();
  fmesh_destp_encoder_if #(.EAw(9), .PLw(4)) bus_a ();

  assign bus_a.in_valid       = bus_d.in_valid;
  assign bus_a.in_head        = bus_d.in_head;
  assign bus_a.in_tail        = bus_d.in_tail;
  assign bus_a.in_dest_e_addr = bus_d.in_dest_e_addr;
  assign bus_a.out_ready      = bus_d.out_ready;

  fmesh_destp_encoder #(.T1(4), .T2(4), .T3(1), .EAw(9), .ROUTE_TYPE("DETERMINISTIC"), .PLw(4)) dut_det (
    .clk(clk), .reset(reset), .current_r_addr(cur_addr), .err_cnt(err_det), .bus(bus_d)
  );

  fmesh_destp_encoder #(.T1(4), .T2(4), .T3(1), .EAw(9), .ROUTE_TYPE("ADAPTIVE"), .PLw(4)) dut_ad (
    .clk(clk), .reset(reset), .current_r_addr(cur_addr), .err_cnt(err_ad), .bus(bus_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected contents of the output slot plus packet bookkeeping.
  bit         m_valid, m_head, m_tail, m_open, m_drop;
  logic [3:0] m_coded_det, m_coded_ad, m_lp;
  int         m_err;

  function automatic logic [3:0] exp_route(logic [3:0] cur, logic [8:0] dest, bit adaptive);
    int cx = cur % 4;
    int cy = cur / 4;
    int dx = dest % 4;
    int dy = (dest / 4) % 4;
    bit east  = dx > cx;
    bit north = dy < cy;
    bit xm    = dx != cx;
    bit ym    = dy != cy;
    if (!adaptive && xm) ym = 1'b0;
    return {east, north, xm, ym};
  endfunction

  function automatic bit exp_addr_bad(logic [8:0] dest);
`ifdef FMESH_DESTP_ADDR_CHECK_EN
    return ((dest % 4) > 3) || (((dest / 4) % 4) > 3) || ((dest / 16) > 4);
`else
    return (dest === 9'hxxx);
`endif
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_head = 0; m_tail = 0; m_open = 0; m_drop = 0;
    m_coded_det = 4'd0; m_coded_ad = 4'd0; m_lp = 4'd0; m_err = 0;
  endfunction

  function automatic void model_advance(bit v, bit h, bit t, logic [8:0] dest, bit ordy);
    bit rdy = !m_valid || ordy;
    bit bad = exp_addr_bad(dest);
    if (m_valid && ordy) m_valid = 0;
    if (!(v && rdy)) return;
    if (m_drop) begin
      if (t) m_drop = 0;
      return;
    end
    if (h) begin
      if ((m_open || bad) && m_err < 255) m_err++;
      if (bad) begin
        m_open = 0;
        m_drop = !t;
      end else begin
        m_valid = 1; m_head = 1; m_tail = t;
        m_coded_det = exp_route(cur_addr, dest, 1'b0);
        m_coded_ad  = exp_route(cur_addr, dest, 1'b1);
        m_lp        = 4'((dest / 16) % 16);
        m_open      = !t;
      end
    end else if (m_open) begin
      m_valid = 1; m_head = 0; m_tail = t;
      m_open  = !t;
    end else begin
      if (m_err < 255) m_err++;
      m_drop = !t;
    end
  endfunction

  // Drive one cycle of inputs (called just after a rising edge), then step the model.
  task automatic cycle(input bit v, input bit h, input bit t, input logic [8:0] dest, input bit ordy);
    bus_d.in_valid       = v;
    bus_d.in_head        = h;
    bus_d.in_tail        = t;
    bus_d.in_dest_e_addr = dest;
    bus_d.out_ready      = ordy;
    @(negedge clk);
    model_advance(v, h, t, dest, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_d.in_valid = 0; bus_d.in_head = 0; bus_d.in_tail = 0;
    bus_d.in_dest_e_addr = '0; bus_d.out_ready = 1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    bus_d.in_valid = 0; bus_d.in_head = 0; bus_d.in_tail = 0;
    bus_d.in_dest_e_addr = '0; bus_d.out_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (bus_d.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus_d.out_valid); end
    checks++; if (bus_d.out_head !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_head: got %b expected 0", bus_d.out_head); end
    checks++; if (bus_d.out_tail !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_tail: got %b expected 0", bus_d.out_tail); end
    checks++; if (bus_d.dest_port_coded !== 4'b0000) begin errors++; $display("[TB] FAIL reset_coded: got %b expected 0000", bus_d.dest_port_coded); end
    checks++; if (bus_d.endp_localp_num !== 4'd0) begin errors++; $display("[TB] FAIL reset_localp: got %0d expected 0", bus_d.endp_localp_num); end
    checks++; if (err_det !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_det); end
    checks++; if (bus_d.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus_d.in_ready); end
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_det_route();
    do_reset();
    cur_addr = {2'd1, 2'd1};
    cycle(1, 1, 0, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL east_head_valid: got %b expected 1", bus_d.out_valid); end
    checks++; if (bus_d.dest_port_coded !== 4'b1010) begin errors++; $display("[TB] FAIL east_head_coded: got %b expected 1010", bus_d.dest_port_coded); end
    checks++; if (bus_a.dest_port_coded !== 4'b1011) begin errors++; $display("[TB] FAIL east_head_coded_adaptive: got %b expected 1011", bus_a.dest_port_coded); end
    checks++; if (bus_d.endp_localp_num !== 4'd0) begin errors++; $display("[TB] FAIL east_head_localp: got %0d expected 0", bus_d.endp_localp_num); end
    checks++; if (bus_d.out_head !== 1'b1) begin errors++; $display("[TB] FAIL east_head_flag: got %b expected 1", bus_d.out_head); end
    cycle(1, 0, 1, {5'd9, 2'd0, 2'd0}, 1);
    checks++; if (bus_d.dest_port_coded !== 4'b1010 || bus_d.out_tail !== 1'b1 || bus_d.out_head !== 1'b0) begin errors++; $display("[TB] FAIL east_tail_held: got coded=%b head=%b tail=%b expected 1010/0/1", bus_d.dest_port_coded, bus_d.out_head, bus_d.out_tail); end
    cycle(1, 1, 1, {5'd2, 2'd0, 2'd1}, 1);
    checks++; if (bus_d.dest_port_coded !== 4'b0101) begin errors++; $display("[TB] FAIL north_single_coded: got %b expected 0101", bus_d.dest_port_coded); end
    checks++; if (bus_d.endp_localp_num !== 4'd2) begin errors++; $display("[TB] FAIL north_single_localp: got %0d expected 2", bus_d.endp_localp_num); end
    cycle(1, 1, 0, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_head !== 1'b1 || bus_d.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_back_to_idle: got valid=%b head=%b expected 1/1", bus_d.out_valid, bus_d.out_head); end
    checks++; if (err_det !== 8'd0) begin errors++; $display("[TB] FAIL single_no_error: got %0d expected 0", err_det); end
    cycle(1, 0, 1, {5'd0, 2'd0, 2'd0}, 1);
    cycle(0, 0, 0, {5'd0, 2'd0, 2'd0}, 1);
  endtask

  task automatic test_local_stall();
    do_reset();
    cur_addr = {2'd0, 2'd2};
    cycle(1, 1, 0, {5'd2, 2'd0, 2'd2}, 1);
    checks++; if (bus_d.dest_port_coded !== 4'b0000 || bus_d.endp_localp_num !== 4'd2) begin errors++; $display("[TB] FAIL local_head: got coded=%b lp=%0d expected 0000/2", bus_d.dest_port_coded, bus_d.endp_localp_num); end
    cycle(1, 0, 0, {5'd7, 2'd3, 2'd1}, 1);
    checks++; if (bus_d.out_valid !== 1'b1 || bus_d.out_head !== 1'b0 || bus_d.dest_port_coded !== 4'b0000 || bus_d.endp_localp_num !== 4'd2) begin errors++; $display("[TB] FAIL local_body: got v=%b h=%b coded=%b lp=%0d expected 1/0/0000/2", bus_d.out_valid, bus_d.out_head, bus_d.dest_port_coded, bus_d.endp_localp_num); end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, {5'd3, 2'd1, 2'd0}, 0);
      checks++; if (bus_d.out_valid !== 1'b1 || bus_d.out_tail !== 1'b0 || bus_d.dest_port_coded !== 4'b0000) begin errors++; $display("[TB] FAIL stall_hold: got v=%b t=%b coded=%b expected 1/0/0000", bus_d.out_valid, bus_d.out_tail, bus_d.dest_port_coded); end
      checks++; if (bus_d.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready: got %b expected 0", bus_d.in_ready); end
    end
    cycle(1, 0, 1, {5'd3, 2'd1, 2'd0}, 1);
    checks++; if (bus_d.out_tail !== 1'b1 || bus_d.endp_localp_num !== 4'd2 || bus_d.dest_port_coded !== 4'b0000) begin errors++; $display("[TB] FAIL local_tail: got t=%b coded=%b lp=%0d expected 1/0000/2", bus_d.out_tail, bus_d.dest_port_coded, bus_d.endp_localp_num); end
    cycle(0, 0, 0, {5'd0, 2'd0, 2'd0}, 1);
    checks++; if (bus_d.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL local_drained: got %b expected 0", bus_d.out_valid); end
  endtask

  task automatic test_adaptive();
    do_reset();
    cur_addr = {2'd1, 2'd1};
    cycle(1, 1, 1, {5'd0, 2'd3, 2'd0}, 1);
    checks++; if (bus_a.dest_port_coded !== 4'b0011) begin errors++; $display("[TB] FAIL adaptive_coded: got %b expected 0011", bus_a.dest_port_coded); end
    checks++; if (bus_d.dest_port_coded !== 4'b0010) begin errors++; $display("[TB] FAIL xy_first_coded: got %b expected 0010", bus_d.dest_port_coded); end
    cycle(0, 0, 0, {5'd0, 2'd0, 2'd0}, 1);
  endtask

  task automatic test_errors();
    do_reset();
    cur_addr = {2'd1, 2'd1};
    cycle(1, 0, 0, {5'd1, 2'd1, 2'd1}, 1);
    checks++; if (bus_d.out_valid !== 1'b0 || err_det !== 8'd1) begin errors++; $display("[TB] FAIL stray_body: got v=%b err=%0d expected 0/1", bus_d.out_valid, err_det); end
    cycle(1, 0, 1, {5'd1, 2'd1, 2'd1}, 1);
    checks++; if (bus_d.out_valid !== 1'b0 || err_det !== 8'd1) begin errors++; $display("[TB] FAIL drop_tail: got v=%b err=%0d expected 0/1", bus_d.out_valid, err_det); end
    cycle(1, 1, 1, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b1 || bus_d.out_head !== 1'b1) begin errors++; $display("[TB] FAIL after_drop_head: got v=%b h=%b expected 1/1", bus_d.out_valid, bus_d.out_head); end
    for (int i = 0; i < 300; i++) begin
      cycle(1, 0, 1, 9'(i), 1);
      if (i == 99) begin
        checks++; if (err_det !== 8'd101) begin errors++; $display("[TB] FAIL err_count_101: got %0d expected 101", err_det); end
      end
    end
    checks++; if (err_det !== 8'd255) begin errors++; $display("[TB] FAIL err_saturate: got %0d expected 255", err_det); end
    checks++; if (bus_d.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_no_output: got %b expected 0", bus_d.out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    cur_addr = {2'd1, 2'd1};
    cycle(1, 1, 0, {5'd0, 2'd2, 2'd3}, 0);
    checks++; if (bus_d.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midpkt_head: got %b expected 1", bus_d.out_valid); end
    bus_d.in_valid = 0;
    #2;
    reset = 1;
    #1;
    checks++; if (bus_d.out_valid !== 1'b0 || bus_d.dest_port_coded !== 4'b0000) begin errors++; $display("[TB] FAIL async_reset: got v=%b coded=%b expected 0/0000", bus_d.out_valid, bus_d.dest_port_coded); end
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    cycle(1, 0, 1, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b0 || err_det !== 8'd1) begin errors++; $display("[TB] FAIL post_reset_body: got v=%b err=%0d expected 0/1", bus_d.out_valid, err_det); end
    cycle(1, 1, 1, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b1 || bus_d.out_head !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_head: got v=%b h=%b expected 1/1", bus_d.out_valid, bus_d.out_head); end
  endtask

  task automatic test_addr_check();
    do_reset();
    cur_addr = {2'd1, 2'd1};
`ifdef FMESH_DESTP_ADDR_CHECK_EN
    cycle(1, 1, 0, {5'd6, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b0 || err_det !== 8'd1) begin errors++; $display("[TB] FAIL bad_head_dropped: got v=%b err=%0d expected 0/1", bus_d.out_valid, err_det); end
    cycle(1, 0, 0, {5'd0, 2'd0, 2'd0}, 1);
    cycle(1, 0, 1, {5'd0, 2'd0, 2'd0}, 1);
    checks++; if (bus_d.out_valid !== 1'b0 || err_det !== 8'd1) begin errors++; $display("[TB] FAIL bad_packet_dropped: got v=%b err=%0d expected 0/1", bus_d.out_valid, err_det); end
    cycle(1, 1, 1, {5'd0, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL after_bad_packet: got %b expected 1", bus_d.out_valid); end
`else
    cycle(1, 1, 1, {5'd6, 2'd2, 2'd3}, 1);
    checks++; if (bus_d.out_valid !== 1'b1 || bus_d.endp_localp_num !== 4'd6 || err_det !== 8'd0) begin errors++; $display("[TB] FAIL unchecked_ep6: got v=%b lp=%0d err=%0d expected 1/6/0", bus_d.out_valid, bus_d.endp_localp_num, err_det); end
`endif
    cycle(0, 0, 0, {5'd0, 2'd0, 2'd0}, 1);
  endtask

  task automatic test_random();
    do_reset();
    cur_addr = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      bit         v    = ($urandom_range(0, 3) != 0);
      bit         h    = ($urandom_range(0, 3) == 0);
      bit         t    = ($urandom_range(0, 2) == 0);
      bit         ordy = ($urandom_range(0, 3) != 0);
      logic [8:0] dest = 9'($urandom);
      cycle(v, h, t, dest, ordy);
      checks++; if (bus_d.out_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid @%0d: got %b expected %b", i, bus_d.out_valid, m_valid); end
      checks++; if (bus_d.in_ready !== (!m_valid || ordy)) begin errors++; $display("[TB] FAIL rand_in_ready @%0d: got %b expected %b", i, bus_d.in_ready, (!m_valid || ordy)); end
      checks++; if (err_det !== 8'(m_err) || err_ad !== 8'(m_err)) begin errors++; $display("[TB] FAIL rand_err @%0d: got %0d/%0d expected %0d", i, err_det, err_ad, m_err); end
      if (m_valid) begin
        checks++;
        if (bus_d.out_head !== m_head || bus_d.out_tail !== m_tail || bus_d.dest_port_coded !== m_coded_det ||
            bus_a.dest_port_coded !== m_coded_ad || bus_d.endp_localp_num !== m_lp) begin
          errors++;
          $display("[TB] FAIL rand_flit @%0d: got h=%b t=%b det=%b ad=%b lp=%0d expected h=%b t=%b det=%b ad=%b lp=%0d",
                   i, bus_d.out_head, bus_d.out_tail, bus_d.dest_port_coded, bus_a.dest_port_coded, bus_d.endp_localp_num,
                   m_head, m_tail, m_coded_det, m_coded_ad, m_lp);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1;
    cur_addr = '0;
    model_reset();
    test_reset();
    test_det_route();
    test_local_stall();
    test_adaptive();
    test_errors();
    test_reset_mid_packet();
    test_addr_check();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
